position_ring_scheduler: RTL and testbench

Sequencer for a ring of position-ring nodes. It drives the shared `dispatch` code and `double_buffer` select into every node, then walks the ring through clear, batch load, circulation and drain. It repeats batches until every node reports its cell exhausted, then flips the double buffer and signals step completion to the timestep controller. A watchdog forces the ring into a safe cleared state if a batch never finishes.

---
 rtl/ring_pkg.sv | 47 ++++
 rtl/position_ring_scheduler.sv | 170 +++++++++++++++++
 tb/tb_position_ring_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: shared definitions for the position-ring scheduler and its nodes.
//   - ring_state_e : scheduler state encoding
//   - DISP_*       : ring command codes broadcast on `dispatch`
//   - NULL_PARTICLE: empty-slot particle encoding (bit 96 set), used by the nodes
package ring_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAULT = 3'd6
    } ring_state_e;

    localparam logic [1:0] DISP_IDLE  = 2'b00;
    localparam logic [1:0] DISP_LOAD  = 2'b01;
    localparam logic [1:0] DISP_RUN   = 2'b10;
    localparam logic [1:0] DISP_CLEAR = 2'b11;

    localparam int          PARTICLE_W    = 97;
    localparam int          NULL_BIT      = 96;
    localparam logic [96:0] NULL_PARTICLE = {1'b1, 96'd0};

    // Ring command for a given scheduler state; unknown encodings command a clear.
    function automatic logic [1:0] dispatch_of(input ring_state_e st);
        logic [1:0] code;
        case (st)
            ST_IDLE:  code = DISP_IDLE;
            ST_DONE:  code = DISP_IDLE;
            ST_CLEAR: code = DISP_CLEAR;
            ST_FAULT: code = DISP_CLEAR;
            ST_LOAD:  code = DISP_LOAD;
            ST_RUN:   code = DISP_RUN;
            ST_DRAIN: code = DISP_RUN;
            default:  code = DISP_CLEAR;
        endcase
        return code;
    endfunction

    // True when a particle word is the empty-slot marker.
    function automatic logic is_null_particle(input logic [96:0] p);
        return p[NULL_BIT];
    endfunction

endpackage

// File: rtl/position_ring_scheduler.sv
// position_ring_scheduler: sequences a ring of position-ring nodes through
// clear, batch load, circulation and drain, repeating batches until every node
// reports its cell exhausted, then flips the double buffer and pulses step_done.
// A watchdog drops the ring into a cleared FAULT state if a batch hangs.
//
// Ports:
//   clk             in  1     rising-edge clock
//   reset           in  1     asynchronous active-low reset
//   start           in  1     timestep request (ignored while busy)
//   node_done_batch in  NODES per-node batch-complete flags
//   node_done_all   in  NODES per-node cell-exhausted flags
//   node_in_flight  in  NODES per-node traffic-in-ring flags
//   dispatch        out 2     ring command (11 clear, 01 load, 10 run, 00 idle)
//   double_buffer   out 1     bank select for all nodes
//   busy            out 1     high from CLEAR through DONE
//   step_done       out 1     one-cycle timestep-complete pulse
//   batch_count     out CNTW  batches loaded this step (saturating)
//   timeout         out 1     sticky watchdog fault flag
module position_ring_scheduler
    import ring_pkg::*;
#(
    parameter int NODES        = 8,
    parameter int DRAIN_CYCLES = NODES,
    parameter int TIMEOUT      = 4096,
    parameter int CNTW         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NODES-1:0] node_done_batch,
    input  logic [NODES-1:0] node_done_all,
    input  logic [NODES-1:0] node_in_flight,
    output logic [1:0]       dispatch,
    output logic             double_buffer,
    output logic             busy,
    output logic             step_done,
    output logic [CNTW-1:0]  batch_count,
    output logic             timeout
);

    localparam int QW  = $clog2(DRAIN_CYCLES + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [QW-1:0]   QUIET_LAST = QW'(DRAIN_CYCLES - 1);
    localparam logic [WDW-1:0]  WD_LAST    = WDW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

    ring_state_e     state_r, state_s;
    logic [QW-1:0]   quiet_r, quiet_s;
    logic [WDW-1:0]  wd_r, wd_s;
    logic [CNTW-1:0] batch_count_r, batch_count_s;
    logic            timeout_r, timeout_s;
    logic            dbuf_r, dbuf_s;

    // Next-state, counter and flag logic for the ring sequencer.
    always_comb begin
        state_s       = state_r;
        quiet_s       = quiet_r;
        wd_s          = wd_r;
        batch_count_s = batch_count_r;
        timeout_s     = timeout_r;
        dbuf_s        = dbuf_r;

        case (state_r)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    state_s       = ST_CLEAR;
                    batch_count_s = {CNTW{1'b0}};
                    timeout_s     = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end

            ST_CLEAR: begin
                state_s = ST_LOAD;
            end

            ST_LOAD: begin
                state_s = ST_RUN;
                wd_s    = {WDW{1'b0}};
                if (batch_count_r != CNT_MAX) begin
                    batch_count_s = batch_count_r + CNTW'(1);
                end else begin
                    batch_count_s = batch_count_r;
                end
            end

            ST_RUN: begin
                // Watchdog expiry wins over every other transition.
                if (wd_r == WD_LAST) begin
                    state_s   = ST_FAULT;
                    timeout_s = 1'b1;
                end else begin
                    wd_s = wd_r + WDW'(1);
                    if (&node_done_batch) begin
                        state_s = ST_DRAIN;
                        quiet_s = {QW{1'b0}};
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                if (wd_r == WD_LAST) begin
                    state_s   = ST_FAULT;
                    timeout_s = 1'b1;
                end else begin
                    wd_s = wd_r + WDW'(1);
                    // Any traffic restarts the quiet window; done_all is only
                    // trusted once the ring has been quiet for the full window.
                    if (|node_in_flight) begin
                        quiet_s = {QW{1'b0}};
                    end else if (quiet_r == QUIET_LAST) begin
                        if (&node_done_all) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        quiet_s = quiet_r + QW'(1);
                    end
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                dbuf_s  = ~dbuf_r;
            end

            default: begin
                state_s   = ST_FAULT;
                timeout_s = 1'b1;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            quiet_r       <= {QW{1'b0}};
            wd_r          <= {WDW{1'b0}};
            batch_count_r <= {CNTW{1'b0}};
            timeout_r     <= 1'b0;
            dbuf_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            quiet_r       <= quiet_s;
            wd_r          <= wd_s;
            batch_count_r <= batch_count_s;
            timeout_r     <= timeout_s;
            dbuf_r        <= dbuf_s;
        end
    end

    // Outputs are decodes of registered state or direct register copies.
    always_comb begin
        dispatch      = dispatch_of(state_r);
        busy          = (state_r == ST_CLEAR) || (state_r == ST_LOAD) ||
                        (state_r == ST_RUN)   || (state_r == ST_DRAIN) ||
                        (state_r == ST_DONE);
        step_done     = (state_r == ST_DONE);
        batch_count   = batch_count_r;
        timeout       = timeout_r;
        double_buffer = dbuf_r;
    end

endmodule

// File: tb/tb_position_ring_scheduler.sv
// Directed self-checking bench for position_ring_scheduler
// (NODES=4, DRAIN_CYCLES=4, TIMEOUT=64, CNTW=2).
module tb_position_ring_scheduler;

    localparam int NODES = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [NODES-1:0] node_done_batch;
    logic [NODES-1:0] node_done_all;
    logic [NODES-1:0] node_in_flight;
    logic [1:0]       dispatch;
    logic             double_buffer;
    logic             busy;
    logic             step_done;
    logic [1:0]       batch_count;
    logic             timeout;

    int tests;
    int fails;
    int exp_dbuf;

    position_ring_scheduler #(
        .NODES(4), .DRAIN_CYCLES(4), .TIMEOUT(64), .CNTW(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .node_done_batch(node_done_batch), .node_done_all(node_done_all),
        .node_in_flight(node_in_flight), .dispatch(dispatch),
        .double_buffer(double_buffer), .busy(busy), .step_done(step_done),
        .batch_count(batch_count), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one step of n batches with done_batch always high; done_all is pulsed
    // early during the first RUN (must be ignored) and held from the last drain.
    task automatic multi(input int n);
        int loads, clears, steps, done_k, load2_k;
        loads = 0; clears = 0; steps = 0; done_k = -1; load2_k = -1;
        node_done_batch = 4'hF; node_done_all = 4'h0; node_in_flight = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6 * n + 3; k++) begin
            node_done_all = (k == 3 || k >= 6 * n - 2) ? 4'hF : 4'h0;
            if (dispatch == 2'b11) clears++;
            if (dispatch == 2'b01) begin
                loads++;
                if (loads == 2) load2_k = k;
            end
            if (step_done) begin
                steps++;
                if (done_k < 0) done_k = k;
            end
            tick();
        end
        exp_dbuf = 1 - exp_dbuf;
        chk($sformatf("multi%0d_loads", n), loads, n);
        chk($sformatf("multi%0d_clears", n), clears, 1);
        chk($sformatf("multi%0d_steps", n), steps, 1);
        chk($sformatf("multi%0d_done_cycle", n), done_k, 6 * n + 2);
        chk($sformatf("multi%0d_load2_cycle", n), load2_k, 8);
        chk($sformatf("multi%0d_batch_count", n), int'(batch_count), (n > 3) ? 3 : n);
        chk($sformatf("multi%0d_dbuf", n), int'(double_buffer), exp_dbuf);
        chk($sformatf("multi%0d_idle", n), int'(busy), 0);
        node_done_batch = 4'h0; node_done_all = 4'h0;
    endtask

    initial begin
        int done_k, clears, tmo_k;
        tests = 0; fails = 0; exp_dbuf = 0;
        reset = 1'b0; start = 1'b0;
        node_done_batch = 4'h0; node_done_all = 4'h0; node_in_flight = 4'h0;

        // Reset state
        tick(); tick();
        chk("rst_dispatch", int'(dispatch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_batch_count", int'(batch_count), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_dbuf", int'(double_buffer), 0);
        reset = 1'b1;
        tick(); tick();
        chk("idle_dispatch", int'(dispatch), 0);

        // Single batch: done flags raised in cycle t+4, DONE at t+9
        start = 1'b1;
        tick();                                   // t+1
        start = 1'b0;
        chk("s_clear_dispatch", int'(dispatch), 3);
        chk("s_clear_busy", int'(busy), 1);
        chk("s_clear_count", int'(batch_count), 0);
        tick();                                   // t+2
        chk("s_load_dispatch", int'(dispatch), 1);
        chk("s_load_count", int'(batch_count), 0);
        tick();                                   // t+3
        chk("s_run_dispatch", int'(dispatch), 2);
        chk("s_run_count", int'(batch_count), 1);
        start = 1'b1;                             // ignored while busy
        tick();                                   // t+4
        start = 1'b0;
        chk("s_busy_start_ignored", int'(dispatch), 2);
        node_done_batch = 4'hF; node_done_all = 4'hF;
        tick();                                   // t+5 DRAIN
        chk("s_drain_dispatch", int'(dispatch), 2);
        tick(); tick(); tick();                   // t+8 last drain cycle
        chk("s_drain_end_dispatch", int'(dispatch), 2);
        chk("s_drain_end_step_done", int'(step_done), 0);
        tick();                                   // t+9 DONE
        chk("s_done_step_done", int'(step_done), 1);
        chk("s_done_dispatch", int'(dispatch), 0);
        chk("s_done_busy", int'(busy), 1);
        chk("s_done_dbuf_unchanged", int'(double_buffer), 0);
        start = 1'b1;                             // same cycle as DONE: ignored
        tick();                                   // t+10
        start = 1'b0;
        exp_dbuf = 1;
        chk("s_after_step_done", int'(step_done), 0);
        chk("s_after_busy", int'(busy), 0);
        chk("s_after_dispatch", int'(dispatch), 0);
        chk("s_after_dbuf", int'(double_buffer), exp_dbuf);
        chk("s_after_count", int'(batch_count), 1);
        node_done_batch = 4'h0; node_done_all = 4'h0;
        tick();
        chk("s_no_extra_clear", int'(dispatch), 0);

        // Drain restart: in_flight[2] on quiet count 2 delays DONE from t+8 to t+11
        node_done_batch = 4'hF; node_done_all = 4'hF;
        done_k = -1; clears = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            node_done_batch = (k == 5) ? 4'b1101 : 4'hF;
            node_in_flight  = (k == 6) ? 4'b0100 : 4'h0;
            if (dispatch == 2'b11) clears++;
            if (step_done && done_k < 0) done_k = k;
            tick();
        end
        exp_dbuf = 1 - exp_dbuf;
        chk("restart_done_cycle", done_k, 11);
        chk("restart_clears", clears, 1);
        chk("restart_dbuf", int'(double_buffer), exp_dbuf);
        node_done_batch = 4'h0; node_done_all = 4'h0; node_in_flight = 4'h0;

        // Three batches
        multi(3);

        // Timeout: RUN entered at t+3, watchdog expires after 64 RUN cycles
        tmo_k = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            if (timeout && tmo_k < 0) tmo_k = k;
            tick();
        end
        chk("tmo_fault_cycle", tmo_k, 67);
        chk("tmo_dispatch_held", int'(dispatch), 3);
        chk("tmo_flag", int'(timeout), 1);
        chk("tmo_dbuf_unchanged", int'(double_buffer), exp_dbuf);
        chk("tmo_no_step_done", int'(step_done), 0);
        start = 1'b1;
        tick();                                   // CLEAR
        start = 1'b0;
        chk("rec_clear_dispatch", int'(dispatch), 3);
        chk("rec_timeout_cleared", int'(timeout), 0);
        chk("rec_count_cleared", int'(batch_count), 0);
        chk("rec_dbuf", int'(double_buffer), exp_dbuf);
        tick();                                   // LOAD
        chk("rec_load_dispatch", int'(dispatch), 1);
        tick();                                   // RUN
        node_done_batch = 4'hF;
        tick();                                   // DRAIN q0
        tick();                                   // DRAIN q1
        chk("rec_drain_dispatch", int'(dispatch), 2);

        // Asynchronous reset between clock edges while in DRAIN
        #3;
        reset = 1'b0;
        #1;
        exp_dbuf = 0;
        chk("arst_dispatch", int'(dispatch), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_step_done", int'(step_done), 0);
        chk("arst_count", int'(batch_count), 0);
        chk("arst_dbuf", int'(double_buffer), exp_dbuf);
        node_done_batch = 4'h0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("arst_no_step_done", int'(step_done), 0);
        end
        chk("arst_idle_dispatch", int'(dispatch), 0);

        // Four batches: batch_count saturates at 3 with CNTW=2
        multi(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
